// File: rtl/pdm_modulator.sv
// pdm_modulator: first-order sigma-delta modulator. It turns signed PCM
// samples into a 1-bit PDM stream that advances on the PDM clock strobe.
// A one-entry buffer sits behind a valid/ready handshake, and each sample is
// held for OSR PDM bits.
module pdm_modulator #(
    parameter int WIDTH = 16,
    parameter int OSR   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_clk_rising,
    input  logic [WIDTH-1:0] pcm_data,
    input  logic             pcm_valid,
    output logic             pcm_ready,
    output logic             pdm_out,
    output logic             underrun
);

    // Accumulator width: two guard bits above the sample keep acc + cur - fb
    // inside the representable range for every legal input.
    localparam int AW = WIDTH + 2;
    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic signed [AW-1:0] FS_POS   = AW'(64'sd1 <<< (WIDTH - 1));
    localparam logic signed [AW-1:0] FS_NEG   = -FS_POS;

    // Sign-extend a PCM sample to accumulator width.
    function automatic logic signed [AW-1:0] sext_sample(input logic [WIDTH-1:0] s);
        return {{(AW - WIDTH){s[WIDTH-1]}}, s};
    endfunction

    // Feedback value selected by the previously emitted PDM bit.
    function automatic logic signed [AW-1:0] feedback(input logic bit_out);
        logic signed [AW-1:0] fb;
        if (bit_out) begin
            fb = FS_POS;
        end else begin
            fb = FS_NEG;
        end
        return fb;
    endfunction

    // State registers
    logic signed [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0]        nxt_r;
    logic                    nxt_valid_r;
    logic                    started_r;
    logic [CW-1:0]           osr_cnt_r;
    logic signed [AW-1:0]    acc_r;
    logic                    pdm_r;
    logic                    underrun_r;

    // Next-state values
    logic signed [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0]        nxt_s;
    logic                    nxt_valid_s;
    logic                    started_s;
    logic [CW-1:0]           osr_cnt_s;
    logic signed [AW-1:0]    acc_s;
    logic                    pdm_s;
    logic                    underrun_s;

    logic                    xfer_s;
    logic                    boundary_s;
    logic signed [AW-1:0]    sum_s;

    assign pcm_ready  = !nxt_valid_r;
    assign xfer_s     = pcm_valid && !nxt_valid_r;
    assign boundary_s = m_clk_rising && (osr_cnt_r == CNT_LAST);
    // The modulator always uses the current (old) sample, including on the boundary strobe.
    assign sum_s      = acc_r + sext_sample(cur_r) - feedback(pdm_r);

    assign pdm_out  = pdm_r;
    assign underrun = underrun_r;

    // Next-state logic: modulator step, sample sequencing and handshake buffer.
    always_comb begin
        cur_s       = cur_r;
        nxt_s       = nxt_r;
        nxt_valid_s = nxt_valid_r;
        started_s   = started_r;
        osr_cnt_s   = osr_cnt_r;
        acc_s       = acc_r;
        pdm_s       = pdm_r;
        underrun_s  = 1'b0;

        if (m_clk_rising) begin
            acc_s = sum_s;
            pdm_s = !sum_s[AW-1];
            if (osr_cnt_r == CNT_LAST) begin
                osr_cnt_s = '0;
            end else begin
                osr_cnt_s = osr_cnt_r + CNT_ONE;
            end
        end else begin
            osr_cnt_s = osr_cnt_r;
        end

        if (boundary_s) begin
            if (nxt_valid_r) begin
                // Buffered sample takes over. No transfer can happen now because ready is low.
                cur_s       = nxt_r;
                nxt_valid_s = 1'b0;
                started_s   = 1'b1;
            end else if (xfer_s) begin
                // Sample arriving exactly on the boundary bypasses the buffer.
                cur_s     = pcm_data;
                started_s = 1'b1;
            end else if (started_r) begin
                // Stream has started but nothing is queued: keep the last sample and flag it.
                underrun_s = 1'b1;
            end else begin
                cur_s = cur_r;
            end
        end else if (xfer_s) begin
            nxt_s       = pcm_data;
            nxt_valid_s = 1'b1;
        end else begin
            nxt_s = nxt_r;
        end
    end

    // State register with synchronous reset that overrides strobe and transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r       <= '0;
            nxt_r       <= '0;
            nxt_valid_r <= 1'b0;
            started_r   <= 1'b0;
            osr_cnt_r   <= '0;
            acc_r       <= '0;
            pdm_r       <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            cur_r       <= cur_s;
            nxt_r       <= nxt_s;
            nxt_valid_r <= nxt_valid_s;
            started_r   <= started_s;
            osr_cnt_r   <= osr_cnt_s;
            acc_r       <= acc_s;
            pdm_r       <= pdm_s;
            underrun_r  <= underrun_s;
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed testbench for pdm_modulator (WIDTH=16, OSR=4). Strobes are spaced
// four clk cycles apart. A 64-bit reference model is stepped every cycle next
// to the hand-computed directed checks.
module tb_pdm_modulator;

    localparam int     WIDTH = 16;
    localparam int     OSR   = 4;
    localparam longint FS    = 64'sd32768;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_clk_rising;
    logic [WIDTH-1:0] pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;
    logic             pdm_out;
    logic             underrun;

    always #4 clk = ~clk;

    pdm_modulator #(.WIDTH(WIDTH), .OSR(OSR)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_clk_rising (m_clk_rising),
        .pcm_data     (pcm_data),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .pdm_out      (pdm_out),
        .underrun     (underrun)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] src_q[$];
    logic [WIDTH-1:0] acc_log[$];

    // reference model state
    longint acc_m, cur_m, nxt_m;
    logic   pdm_m, ur_m, nxtv_m, started_m;
    int     osr_m;

    int   ur_cnt, rise_cnt;
    logic prev_ready = 1'b1;
    logic strobe_pdm;

    logic idle_pat [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic signed [WIDTH-1:0] hs_vals [0:7] = '{16'sd100, -16'sd1000, 16'sd300, 16'sd400,
                                               -16'sd500, 16'sd600, 16'sd700, 16'sd800};

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests_run++;
        assert (obs >= lo && obs <= hi) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic model_reset();
        acc_m = 0; cur_m = 0; nxt_m = 0;
        pdm_m = 1'b0; ur_m = 1'b0; nxtv_m = 1'b0; started_m = 1'b0;
        osr_m = 0;
    endtask

    // One clk cycle: drive inputs, clock, step the model, compare outputs.
    task automatic tick(input logic strobe);
        logic   xfer;
        longint din, fb, sum;
        if (src_q.size() > 0) begin
            pcm_valid = 1'b1;
            pcm_data  = src_q[0];
        end else begin
            pcm_valid = 1'b0;
            pcm_data  = '0;
        end
        m_clk_rising = strobe;
        xfer = pcm_valid && pcm_ready && !rst;
        din  = longint'($signed(pcm_data));
        @(posedge clk);
        #1;
        m_clk_rising = 1'b0;
        if (xfer) begin
            acc_log.push_back(pcm_data);
            void'(src_q.pop_front());
        end
        if (rst) begin
            model_reset();
        end else begin
            ur_m = 1'b0;
            if (strobe) begin
                fb    = pdm_m ? FS : -FS;
                sum   = acc_m + cur_m - fb;
                acc_m = sum;
                pdm_m = (sum >= 0);
                if (osr_m < OSR - 1) begin
                    osr_m++;
                    if (xfer) begin nxt_m = din; nxtv_m = 1'b1; end
                end else begin
                    osr_m = 0;
                    if (nxtv_m) begin
                        cur_m = nxt_m; nxtv_m = 1'b0; started_m = 1'b1;
                    end else if (xfer) begin
                        cur_m = din; started_m = 1'b1;
                    end else if (started_m) begin
                        ur_m = 1'b1;
                    end
                end
            end else if (xfer) begin
                nxt_m = din; nxtv_m = 1'b1;
            end
        end
        check("model_pdm_out", pdm_out, pdm_m);
        check("model_underrun", underrun, ur_m);
        check("model_pcm_ready", pcm_ready, !nxtv_m);
        check("model_acc", dut.acc_r, acc_m);
        if (underrun === 1'b1) ur_cnt++;
        if (pcm_ready === 1'b1 && prev_ready === 1'b0) rise_cnt++;
        prev_ready = pcm_ready;
    endtask

    task automatic strobe();
        tick(1'b1);
        strobe_pdm = pdm_out;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic do_reset();
        src_q.delete();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        acc_log.delete();
        ur_cnt   = 0;
        rise_cnt = 0;
    endtask

    // Constant sample: skip to the first load (+extra), then count ones over 1024 strobes.
    task automatic density(input string tag, input logic [WIDTH-1:0] s, input int extra,
                           input int lo, input int hi);
        int ones;
        do_reset();
        for (int i = 0; i < 300; i++) src_q.push_back(s);
        for (int i = 0; i < 4 + extra; i++) strobe();
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            strobe();
            ones += int'(strobe_pdm);
        end
        check_range(tag, ones, lo, hi);
        check({tag, "_no_underrun"}, ur_cnt, 0);
    endtask

    initial begin
        rst          = 1'b1;
        m_clk_rising = 1'b0;
        pcm_valid    = 1'b0;
        pcm_data     = '0;
        model_reset();

        // Reset and idle pattern
        do_reset();
        check("rst_pdm_out", pdm_out, 1'b0);
        check("rst_pcm_ready", pcm_ready, 1'b1);
        check("rst_underrun", underrun, 1'b0);
        check("rst_cur", dut.cur_r, 0);
        for (int i = 0; i < 6; i++) begin
            strobe();
            check("idle_pdm", strobe_pdm, idle_pat[i]);
        end
        for (int i = 0; i < 6; i++) strobe();
        check("idle_no_underrun", ur_cnt, 0);

        // Density and full scale
        density("density_pos_half", 16'sd16384, 0, 767, 769);
        density("density_neg_half", -16'sd16384, 0, 255, 257);
        density("fullscale_neg", 16'h8000, 1, 0, 0);
        density("fullscale_pos", 16'h7FFF, 0, 1023, 1024);

        // Handshake and backpressure
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(hs_vals[i]);
        tick(1'b0);
        check("hs_ready_fall", pcm_ready, 1'b0);
        for (int i = 0; i < 16; i++) strobe();
        check("hs_ready_rises", rise_cnt, 4);
        check("hs_accepted", acc_log.size(), 5);
        for (int i = 0; i < 5; i++) check("hs_order", $signed(acc_log[i]), hs_vals[i]);
        check("hs_cur", dut.cur_r, hs_vals[3]);

        // Underrun after the source stops at two samples
        do_reset();
        src_q.push_back(16'd1000);
        src_q.push_back(16'hF830);
        for (int i = 0; i < 20; i++) strobe();
        check("ur_count", ur_cnt, 3);
        check("ur_cur_hold", dut.cur_r, -16'sd2000);

        // Bypass: sample presented exactly on the boundary strobe with nxt empty
        for (int i = 0; i < 3; i++) strobe();
        src_q.push_back(16'd5000);
        tick(1'b1);
        check("byp_underrun", underrun, 1'b0);
        check("byp_cur", dut.cur_r, 16'sd5000);
        check("byp_ready", pcm_ready, 1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check("byp_ur_count", ur_cnt, 3);

        // Reset mid-operation with nxt occupied
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(hs_vals[4 + i]);
        tick(1'b0);
        for (int i = 0; i < 4; i++) strobe();
        check("mid_nxt_full", pcm_ready, 1'b0);
        src_q.delete();
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        ur_cnt = 0;
        check("mid_rst_pdm_out", pdm_out, 1'b0);
        check("mid_rst_underrun", underrun, 1'b0);
        check("mid_rst_ready", pcm_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            strobe();
            check("mid_idle_pdm", strobe_pdm, idle_pat[i]);
        end
        check("mid_cur_zero", dut.cur_r, 0);
        check("mid_no_underrun", ur_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
# pdm_modulator

Transmit-side counterpart of the PDM microphone path: a first-order sigma-delta modulator that turns signed PCM samples into a 1-bit PDM stream. Bits advance on the `m_clk_rising` strobe of the PDM clock generator, so `pdm_out` is aligned with `M_CLK` for loopback tests, microphone emulation, and PDM DAC/speaker output. Each PCM sample is held for `OSR` PDM bits. The sample source feeds the block through a valid/ready handshake with one sample of buffering.

## Interface
- `WIDTH`, 16: PCM sample width, signed two's complement.
- `OSR`, 64: PDM bits per PCM sample (≥2); 2.5 MHz / 64 ≈ 39 kHz sample rate.

- `clk` input 1: system clock (125 MHz).
- `rst` input 1: synchronous, active-high reset.
- `m_clk_rising` input 1: one-`clk` strobe, one per PDM bit period, from the clock generator.
- `pcm_data` input WIDTH: signed PCM sample.
- `pcm_valid` input 1: `pcm_data` is valid.
- `pcm_ready` output 1: the block can accept a sample this cycle.
- `pdm_out` output 1: PDM bitstream, registered.
- `underrun` output 1: one-`clk` pulse when a sample period ends with no next sample buffered.

## Operation
- State:
  - `cur`: sample being modulated.
  - `nxt` / `nxt_valid`: one-entry buffer.
  - `started`: set by the first sample load.
  - `osr_cnt`: range 0..OSR-1, width $clog2(OSR).
  - `acc`: signed, WIDTH+2 bits.
  - `pdm_out`.
- Handshake:
  - `pcm_ready = !nxt_valid`, combinational from state.
  - A transfer occurs when `pcm_valid && pcm_ready`; the sample is written to `nxt`.
- Modulator, on each `m_clk_rising`:
  - FS = 2^(WIDTH-1).
  - fb = +FS if `pdm_out`==1, else −FS.
  - sum = acc + sext(cur) − fb, computed at WIDTH+2 bits; this range never overflows for any legal input.
  - acc <= sum.
  - `pdm_out` <= (sum ≥ 0).
- Sample sequencing, on `m_clk_rising`:
  - If `osr_cnt` < OSR-1: increment `osr_cnt`.
  - Otherwise `osr_cnt` <= 0 and the sample boundary is handled as follows:
    - `nxt_valid`: `cur` <= `nxt`, `nxt_valid` <= 0, `started` <= 1.
    - No `nxt_valid` but a transfer in the same cycle: the incoming `pcm_data` bypasses straight into `cur`. `nxt_valid` stays 0, `started` <= 1, and no underrun is raised.
    - Neither, with `started`=1: `cur` holds its value and `underrun` pulses for 1 cycle.
    - Neither, with `started`=0: `cur` stays 0 and no underrun is raised.
- Before the first load, `cur`=0, so the output is the idle pattern of ~50% density.
- The modulator uses the old `cur` on the boundary strobe; a new sample first affects the strobe after the boundary.
- `underrun` is never asserted outside a boundary strobe.

## Timing
- Reset values:
  - `pdm_out`=0, `underrun`=0, `pcm_ready`=1.
  - `acc`=0, `cur`=0, `osr_cnt`=0, `nxt_valid`=0, `started`=0.
- `rst` overrides everything, including a strobe or transfer in the same cycle. Reset mid-stream discards `cur` and `nxt`.
- `pdm_out` changes only in the `clk` cycle after an `m_clk_rising` strobe and holds for the full PDM period.
- A sample is accepted in the same cycle as the transfer. `pcm_ready` deasserts the next cycle and reasserts the cycle after the boundary strobe that drains `nxt`.
- Throughput is one sample per OSR strobes. Upstream has at most OSR PDM periods to deliver each sample.
- If strobes are more than 1 cycle apart, all state holds between strobes.

## Test plan
- **Reset/idle** (WIDTH=16, OSR=4, no samples):
  - Directly after reset: `pdm_out`=0 and `pcm_ready`=1.
  - `pdm_out` after strobes 1..6 is 1,1,0,1,0,1.
  - `underrun` never asserts.
- **Density** (constant sample 16384, kept supplied): over 1024 strobes after the first boundary, the ones count is 768±1. Sample −16384 gives 256±1.
- **Full scale**:
  - Sample −32768 gives a steady 0 from the 2nd strobe after load.
  - Sample 32767 gives ≤1 zero per 1024 strobes.
  - `acc` never wraps; checked with an assertion against a 64-bit model.
- **Handshake/backpressure** (OSR=4, `pcm_valid` held high):
  - `pcm_ready` falls after the accept and rises once per 4 strobes.
  - Exactly 1 sample is accepted per boundary, and the model sample order is preserved.
- **Underrun and bypass**:
  - Source stops after 2 samples: one `underrun` pulse per boundary, with `cur` holding the last sample.
  - A sample presented in exactly the boundary cycle with `nxt` empty loads into `cur` with no `underrun`.
- **Reset mid-operation**: asserting `rst` during a strobe with `nxt_valid`=1 returns all outputs to their reset values in the next cycle. The idle pattern then restarts, and the buffered sample is not emitted.
